board_ram_arbiter: RTL

Parametrised shared board memory for the Minesweeper system: one single-port RAM that serves NUM_CH clients (CPU data port, VGA tile fetch, future flood-fill/solver engines) through a request/grant handshake, replacing the fixed two-address-port block RAM. It adds selectable round-robin or fixed-priority arbitration, out-of-range address protection, and a hardware bulk-clear used on new-game reset. It sits between the processor/VGA controller and the board state storage, clocked by the divided system clock.

---
 rtl/board_ram_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/board_ram_arbiter.sv
// Shared single-port board memory for the Minesweeper system: NUM_CH clients arbitrate
// (round-robin or fixed priority) for one access per cycle, with a hardware bulk clear.
module board_ram_arbiter #(
   parameter int                ADDR_W    = 12,
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 4096,
   parameter int                NUM_CH    = 3,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     mode,
   input  logic [NUM_CH-1:0]        req,
   input  logic [NUM_CH-1:0]        we,
   input  logic [NUM_CH*ADDR_W-1:0] addr,
   input  logic [NUM_CH*DATA_W-1:0] wdata,
   output logic [NUM_CH-1:0]        gnt,
   output logic [NUM_CH-1:0]        rvalid,
   output logic [DATA_W-1:0]        rdata,
   input  logic                     clear_start,
   output logic                     clear_busy
);

   localparam int PTR_W  = $clog2(NUM_CH);
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [MEM_AW-1:0] LAST_WORD = MEM_AW'(DEPTH - 1);
   localparam logic [PTR_W-1:0]  LAST_CH   = PTR_W'(NUM_CH - 1);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  gnt_idx;
   logic              grant_any;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              in_range;
   logic [MEM_AW-1:0] mem_idx;
   logic [MEM_AW-1:0] clr_cnt;

   // Priority search starts at ptr in round-robin mode and at channel 0 in fixed mode.
   always_comb begin
      int cand;
      // NOTE: every output of this block gets a default first so no latch is inferred.
      gnt       = '0;
      gnt_idx   = '0;
      grant_any = 1'b0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      cand      = 0;
      if (!reset && !clear_busy) begin
         for (int k = 0; k < NUM_CH; k++) begin
            cand = mode ? k : (int'(ptr) + k) % NUM_CH;
            if (!grant_any && req[cand]) begin
               grant_any  = 1'b1;
               gnt[cand]  = 1'b1;
               gnt_idx    = PTR_W'(cand);
               sel_we     = we[cand];
               sel_addr   = addr[cand*ADDR_W +: ADDR_W];
               sel_wdata  = wdata[cand*DATA_W +: DATA_W];
            end
         end
      end
   end

   assign in_range = (32'(sel_addr) < 32'(DEPTH));
   assign mem_idx  = sel_addr[MEM_AW-1:0];

   // NOTE: the storage array has no reset; only control state is reset, so it maps to block RAM.
   always_ff @(posedge clock) begin
      if (clear_busy)
         mem[clr_cnt] <= CLEAR_VAL;
      else if (grant_any && sel_we && in_range)
         mem[mem_idx] <= sel_wdata;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ptr        <= '0;
         rvalid     <= '0;
         rdata      <= '0;
         clear_busy <= 1'b0;
         clr_cnt    <= '0;
      end else begin
         rvalid <= gnt & ~we;
         if (grant_any && !sel_we)
            rdata <= in_range ? mem[mem_idx] : '0;

         if (grant_any && !mode)
            ptr <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;

         // A start request while already clearing is ignored.
         if (clear_busy) begin
            if (clr_cnt == LAST_WORD) begin
               clear_busy <= 1'b0;
               clr_cnt    <= '0;
            end else begin
               clr_cnt <= clr_cnt + 1'b1;
            end
         end else if (clear_start) begin
            clear_busy <= 1'b1;
            clr_cnt    <= '0;
         end
      end
   end

endmodule
